// File: rtl/fir16_pkg.sv
// fir16 shared widths, state encoding and saturation limits.
// Optional output saturation is selected with FIR16_SAT_EN.
package fir16_pkg;
   localparam int DW   = 24;
   localparam int CW   = 18;
   localparam int PW   = 42;
   localparam int AW   = 48;
   localparam int NTAP = 16;

   localparam logic [DW-1:0] SAT_POS = 24'h7FFFFF;
   localparam logic [DW-1:0] SAT_NEG = 24'h800000;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      RUN,
      DRAIN,
      OUT
   } state_t;
endpackage

// File: rtl/fir16_coef.sv
// fir16 coefficient register file, 16 x 18, registered read port.
// Part of fir16_seq; see FIR16_SAT_EN in the top for saturation.
module fir16_coef
   import fir16_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          cw,
   input  logic [3:0]    ca,
   input  logic [CW-1:0] cd,
   input  logic [3:0]    ra,
   output logic [CW-1:0] rd
);

   logic [CW-1:0] h [NTAP];

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (cw)
         h[ca] <= cd;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd <= '0;
      else
         rd <= h[ra];
   end

endmodule

// File: rtl/fir16_seq.sv
// fir16 sequencer and MAC for an external 16-tap delay line.
// Define FIR16_SAT_EN to saturate dout instead of wrapping.
module fir16_seq
   import fir16_pkg::*;
#(
   parameter int OSHIFT = 17
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   input  logic          din_stb,
   output logic          busy,
   output logic          ovr,
   input  logic          ovr_clr,
   output logic [DW-1:0] sr_d,
   output logic          sr_ce,
   output logic [3:0]    sr_a,
   input  logic [DW-1:0] sr_y,
   input  logic          cw,
   input  logic [3:0]    ca,
   input  logic [CW-1:0] cd,
   output logic [DW-1:0] dout,
   output logic          dout_stb
);

   localparam int TOP = OSHIFT + DW - 1;

   state_t               st;
   logic                 dcnt;
   logic [CW-1:0]        h_q;
   logic signed [DW-1:0] p1_x;
   logic                 p1_v;
   logic                 p1_f;
   logic signed [PW-1:0] p2;
   logic                 p2_v;
   logic                 p2_f;
   logic [AW-1:0]        acc;

   function automatic logic [DW-1:0] fld(
      input logic [AW-1:0] a
   );
      logic [DW-1:0] r;
      r = a[TOP:OSHIFT];
`ifdef FIR16_SAT_EN
      if (a[AW-1:TOP] != {(AW-TOP){a[TOP]}})
         r = a[AW-1] ? SAT_NEG : SAT_POS;
`endif
      return r;
   endfunction

   fir16_coef u_coef (
      .clk (clk),
      .rst (rst),
      .cw  (cw),
      .ca  (ca),
      .cd  (cd),
      .ra  (sr_a),
      .rd  (h_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= IDLE;
         busy     <= 1'b0;
         sr_ce    <= 1'b0;
         sr_a     <= '0;
         sr_d     <= '0;
         dout     <= '0;
         dout_stb <= 1'b0;
         dcnt     <= 1'b0;
      end else begin
         sr_ce    <= 1'b0;
         dout_stb <= 1'b0;
         unique case (st)
            IDLE: begin
               if (din_stb) begin
                  sr_d  <= din;
                  sr_ce <= 1'b1;
                  busy  <= 1'b1;
                  st    <= SHIFT;
               end
            end
            SHIFT: begin
               sr_a <= '0;
               st   <= RUN;
            end
            RUN: begin
               if (sr_a == 4'd15) begin
                  sr_a <= '0;
                  dcnt <= 1'b0;
                  st   <= DRAIN;
               end else begin
                  sr_a <= sr_a + 4'd1;
               end
            end
            DRAIN: begin
               dcnt <= 1'b1;
               if (dcnt)
                  st <= OUT;
            end
            OUT: begin
               dout     <= fld(acc);
               dout_stb <= 1'b1;
               busy     <= 1'b0;
               st       <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

   // A coincident clear loses to a fresh overrun.
   always_ff @(posedge clk) begin
      if (rst)
         ovr <= 1'b0;
      else if (din_stb && busy)
         ovr <= 1'b1;
      else if (ovr_clr)
         ovr <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_x <= '0;
         p1_v <= 1'b0;
         p1_f <= 1'b0;
         p2   <= '0;
         p2_v <= 1'b0;
         p2_f <= 1'b0;
         acc  <= '0;
      end else begin
         p1_x <= sr_y;
         p1_v <= (st == RUN);
         p1_f <= (st == RUN) && (sr_a == 4'd0);
         p2   <= p1_x * $signed(h_q);
         p2_v <= p1_v;
         p2_f <= p1_f;
         if (p2_v) begin
            if (p2_f)
               acc <= {{(AW-PW){p2[PW-1]}}, p2};
            else
               acc <= acc + {{(AW-PW){p2[PW-1]}}, p2};
         end
      end
   end

endmodule

// File: tb/tb_fir16_seq.sv
// Self-checking bench for fir16_seq with a behavioural delay line.
// Honours FIR16_SAT_EN in its reference model.
module tb_fir16_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] din;
   logic        din_stb;
   logic        busy;
   logic        ovr;
   logic        ovr_clr;
   logic [23:0] sr_d;
   logic        sr_ce;
   logic [3:0]  sr_a;
   logic [23:0] sr_y;
   logic        cw;
   logic [3:0]  ca;
   logic [17:0] cd;
   logic [23:0] dout;
   logic        dout_stb;

   int vecs = 0;
   int errs = 0;

   logic [23:0]        expq [$];
   logic signed [17:0] hm [16];
   logic signed [23:0] xm [16];
   logic [23:0]        sr [16] = '{default: 24'd0};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sr_ce) begin
         for (int i = 15; i > 0; i--)
            sr[i] <= sr[i-1];
         sr[0] <= sr_d;
      end
   end

   assign sr_y = sr[sr_a];

   fir16_seq #(.OSHIFT(17)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_stb  (din_stb),
      .busy     (busy),
      .ovr      (ovr),
      .ovr_clr  (ovr_clr),
      .sr_d     (sr_d),
      .sr_ce    (sr_ce),
      .sr_a     (sr_a),
      .sr_y     (sr_y),
      .cw       (cw),
      .ca       (ca),
      .cd       (cd),
      .dout     (dout),
      .dout_stb (dout_stb)
   );

   function automatic logic [23:0] model();
      longint      s;
      logic [47:0] a;
      logic [23:0] r;
      s = 0;
      for (int k = 0; k < 16; k++)
         s += longint'(hm[k]) * longint'(xm[k]);
      a = s[47:0];
      r = a[40:17];
`ifdef FIR16_SAT_EN
      if (a[47:40] != {8{a[40]}})
         r = a[47] ? 24'h800000 : 24'h7FFFFF;
`endif
      return r;
   endfunction

   task automatic shift_model(input logic [23:0] x);
      for (int k = 15; k > 0; k--)
         xm[k] = xm[k-1];
      xm[0] = x;
   endtask

   task automatic wcoef(input int a, input int d);
      @(negedge clk);
      cw = 1'b1;
      ca = 4'(a);
      cd = 18'(d);
      hm[a] = 18'(d);
      @(negedge clk);
      cw = 1'b0;
   endtask

   task automatic run_sample(
      input  logic [23:0] x,
      output logic [23:0] got,
      output int          lat
   );
      @(negedge clk);
      din = x;
      din_stb = 1'b1;
      shift_model(x);
      expq.push_back(model());
      @(negedge clk);
      din_stb = 1'b0;
      lat = 1;
      while (!dout_stb && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      got = dout;
   endtask

   task automatic test_reset();
      logic [58:0] o;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      o = {busy, ovr, sr_ce, sr_a, sr_d, dout, dout_stb};
      vecs++;
      if (o !== '0) begin
         errs++;
         $display("FAIL reset_outputs got %h want 0", o);
      end
   endtask

   task automatic test_single_tap();
      logic [23:0] got, e;
      int lat;
      logic [23:0] xs [4];
      logic [23:0] ks [4];
      xs = '{24'd1024, 24'd0, 24'd0, 24'd0};
      ks = '{24'd0, 24'd0, 24'd0, 24'd512};
      for (int k = 0; k < 16; k++)
         wcoef(k, (k == 3) ? 65536 : 0);
      for (int i = 0; i < 4; i++) begin
         run_sample(xs[i], got, lat);
         e = expq.pop_front();
         vecs++;
         if (lat != 21 || got !== e || got !== ks[i]) begin
            errs++;
            $display("FAIL single_tap[%0d] got %h lat %0d want %h lat 21",
                     i, got, lat, ks[i]);
         end
      end
   endtask

   task automatic test_latency();
      logic [3:0]  ea;
      logic [23:0] e;
      @(negedge clk);
      din = 24'd2000;
      din_stb = 1'b1;
      shift_model(din);
      expq.push_back(model());
      for (int i = 1; i <= 22; i++) begin
         @(negedge clk);
         if (i == 1)
            din_stb = 1'b0;
         ea = (i >= 2 && i <= 17) ? 4'(i - 2) : 4'd0;
         vecs++;
         if (sr_ce !== (i == 1) || sr_a !== ea ||
             dout_stb !== (i == 21) ||
             busy !== (i >= 1 && i <= 20)) begin
            errs++;
            $display("FAIL latency c%0d got ce%b a%0d stb%b busy%b want ce%b a%0d stb%b busy%b",
                     i, sr_ce, sr_a, dout_stb, busy, i == 1, ea,
                     i == 21, i >= 1 && i <= 20);
         end
         if (i == 21) begin
            e = expq.pop_front();
            vecs++;
            if (dout !== e) begin
               errs++;
               $display("FAIL latency_dout got %h want %h", dout, e);
            end
         end
      end
   endtask

   task automatic test_overrun();
      logic [23:0] e;
      @(negedge clk);
      din = 24'd777;
      din_stb = 1'b1;
      shift_model(din);
      expq.push_back(model());
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk);
         if (i == 1)
            din_stb = 1'b0;
         if (i == 6)
            din_stb = 1'b0;
         vecs++;
         if (ovr !== (i >= 6)) begin
            errs++;
            $display("FAIL overrun_ovr c%0d got %b want %b", i, ovr, i >= 6);
         end
         if (i == 5) begin
            din = 24'd999;
            din_stb = 1'b1;
         end
      end
      e = expq.pop_front();
      vecs++;
      if (dout_stb !== 1'b1 || dout !== e) begin
         errs++;
         $display("FAIL overrun_dout got %h stb %b want %h stb 1",
                  dout, dout_stb, e);
      end
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      vecs++;
      if (ovr !== 1'b0) begin
         errs++;
         $display("FAIL overrun_clear got %b want 0", ovr);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] e;
      @(negedge clk);
      din = 24'h012345;
      din_stb = 1'b1;
      shift_model(din);
      expq.push_back(model());
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk);
         if (i == 1)
            din_stb = 1'b0;
      end
      e = expq.pop_front();
      vecs++;
      if (dout_stb !== 1'b1 || dout !== e) begin
         errs++;
         $display("FAIL b2b_first got %h stb %b want %h stb 1",
                  dout, dout_stb, e);
      end
      din = 24'hFEDCBA;
      din_stb = 1'b1;
      shift_model(din);
      expq.push_back(model());
      for (int j = 1; j <= 21; j++) begin
         @(negedge clk);
         if (j == 1) begin
            din_stb = 1'b0;
            vecs++;
            if (busy !== 1'b1 || ovr !== 1'b0) begin
               errs++;
               $display("FAIL b2b_accept got busy %b ovr %b want 1 0",
                        busy, ovr);
            end
         end
      end
      e = expq.pop_front();
      vecs++;
      if (dout_stb !== 1'b1 || dout !== e) begin
         errs++;
         $display("FAIL b2b_second got %h stb %b want %h stb 1",
                  dout, dout_stb, e);
      end
   endtask

   task automatic test_coef_run();
      logic [23:0] got, e;
      int lat;
      for (int k = 0; k < 16; k++)
         wcoef(k, 1000 * (k + 1) - 9000);
      for (int i = 0; i < 16; i++) begin
         run_sample(24'(i * 40000 - 300000), got, lat);
         e = expq.pop_front();
         vecs++;
         if (lat != 21 || got !== e) begin
            errs++;
            $display("FAIL coef_fill[%0d] got %h lat %0d want %h",
                     i, got, lat, e);
         end
      end
      @(negedge clk);
      din = 24'h234567;
      din_stb = 1'b1;
      shift_model(din);
      for (int i = 1; i <= 21; i++) begin
         @(negedge clk);
         if (i == 1)
            din_stb = 1'b0;
         if (i == 10) begin
            cw = 1'b1;
            ca = 4'd15;
            cd = 18'h1F000;
            hm[15] = 18'h1F000;
            expq.push_back(model());
         end
         if (i == 11)
            cw = 1'b0;
      end
      e = expq.pop_front();
      vecs++;
      if (dout_stb !== 1'b1 || dout !== e) begin
         errs++;
         $display("FAIL coef_run got %h stb %b want %h stb 1",
                  dout, dout_stb, e);
      end
   endtask

   task automatic test_reset_run();
      logic [58:0] o;
      logic [23:0] got, e;
      int lat, seen;
      @(negedge clk);
      din = 24'h0ABCDE;
      din_stb = 1'b1;
      shift_model(din);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i == 1)
            din_stb = 1'b0;
         if (i == 8)
            rst = 1'b1;
      end
      rst = 1'b0;
      o = {busy, ovr, sr_ce, sr_a, sr_d, dout, dout_stb};
      vecs++;
      if (o !== '0) begin
         errs++;
         $display("FAIL reset_run_outputs got %h want 0", o);
      end
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (dout_stb)
            seen++;
      end
      vecs++;
      if (seen != 0) begin
         errs++;
         $display("FAIL reset_run_stb got %0d strobes want 0", seen);
      end
      run_sample(24'h765432, got, lat);
      e = expq.pop_front();
      vecs++;
      if (lat != 21 || got !== e) begin
         errs++;
         $display("FAIL reset_run_next got %h lat %0d want %h lat 21",
                  got, lat, e);
      end
   endtask

   task automatic test_saturation();
      logic [23:0] got, e, k16;
      int lat;
`ifdef FIR16_SAT_EN
      k16 = 24'h7FFFFF;
`else
      k16 = 24'hFFFBF0;
`endif
      for (int k = 0; k < 16; k++)
         wcoef(k, 131071);
      for (int i = 0; i < 16; i++) begin
         run_sample(24'h7FFFFF, got, lat);
         e = expq.pop_front();
         vecs++;
         if (lat != 21 || got !== e) begin
            errs++;
            $display("FAIL sat[%0d] got %h lat %0d want %h",
                     i, got, lat, e);
         end
      end
      vecs++;
      if (got !== k16) begin
         errs++;
         $display("FAIL sat_final got %h want %h", got, k16);
      end
   endtask

   initial begin
      rst = 1'b1;
      din = '0;
      din_stb = 1'b0;
      ovr_clr = 1'b0;
      cw = 1'b0;
      ca = '0;
      cd = '0;
      for (int k = 0; k < 16; k++) begin
         hm[k] = '0;
         xm[k] = '0;
      end
      test_reset();
      test_single_tap();
      test_latency();
      test_overrun();
      test_back_to_back();
      test_coef_run();
      test_reset_run();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
